// File: rtl/timer_share_ctrl.sv
// Shares one interval timer among NREQ requesters as one-shot timeouts.
// Define TIMER_SHARE_RR_EN for round-robin arbitration (default: fixed priority).
module timer_share_ctrl #(
  parameter int NREQ       = 2,
  parameter int MIN_PERIOD = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [32*NREQ-1:0] req_period,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic              tmr_irq
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [31:0] MINP = 32'(MIN_PERIOD);

  localparam logic [2:0] A_STAT = 3'd0;
  localparam logic [2:0] A_CTRL = 3'd1;
  localparam logic [2:0] A_PL   = 3'd2;
  localparam logic [2:0] A_PH   = 3'd3;

  localparam logic [15:0] C_START = 16'h0005;
  localparam logic [15:0] C_STOP  = 16'h0008;

  typedef enum logic [2:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL,
    WAIT, ABORT, CLR, DONE
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   own_q;
  logic [31:0]     per_q;
  logic            irq_hit_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic [2:0]      addr_q;
  logic            cs_q;
  logic            wn_q;
  logic [15:0]     wd_q;

  logic [IW-1:0]   sel;
  logic [31:0]     raw_per;
  logic [31:0]     clamp_per;

`ifdef TIMER_SHARE_RR_EN
  logic [IW-1:0]   rr_q;
  logic            found;

  // first set request at or after the rr pointer, wrapping
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(rr_q) + k) % NREQ]) begin
        sel = IW'((int'(rr_q) + k) % NREQ);
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    sel = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) sel = IW'(k);
    end
  end
`endif

  assign raw_per   = req_period[32*int'(sel) +: 32];
  assign clamp_per = (raw_per < MINP) ? MINP : raw_per;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      own_q     <= '0;
      per_q     <= '0;
      irq_hit_q <= 1'b0;
      grant_q   <= '0;
      done_q    <= '0;
      addr_q    <= '0;
      cs_q      <= 1'b0;
      wn_q      <= 1'b1;
      wd_q      <= '0;
`ifdef TIMER_SHARE_RR_EN
      rr_q      <= '0;
`endif
    end else begin
      addr_q <= '0;
      cs_q   <= 1'b0;
      wn_q   <= 1'b1;
      wd_q   <= '0;
      done_q <= '0;
      // bus outputs are set on entry so each write lines up with its state
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            own_q   <= sel;
            per_q   <= clamp_per;
            grant_q <= NREQ'(1) << sel;
            cs_q    <= 1'b1;
            wn_q    <= 1'b0;
            addr_q  <= A_PL;
            wd_q    <= clamp_per[15:0];
            state_q <= WR_PL;
          end
        end
        WR_PL: begin
          cs_q    <= 1'b1;
          wn_q    <= 1'b0;
          addr_q  <= A_PH;
          wd_q    <= per_q[31:16];
          state_q <= WR_PH;
        end
        WR_PH: begin
          cs_q    <= 1'b1;
          wn_q    <= 1'b0;
          addr_q  <= A_CTRL;
          wd_q    <= C_START;
          state_q <= WR_CTRL;
        end
        WR_CTRL: state_q <= WAIT;
        WAIT: begin
          if (tmr_irq) begin
            irq_hit_q <= 1'b1;
            cs_q      <= 1'b1;
            wn_q      <= 1'b0;
            addr_q    <= A_STAT;
            state_q   <= CLR;
          end else if (!req[own_q]) begin
            irq_hit_q <= 1'b0;
            cs_q      <= 1'b1;
            wn_q      <= 1'b0;
            addr_q    <= A_CTRL;
            wd_q      <= C_STOP;
            state_q   <= ABORT;
          end
        end
        ABORT: begin
          cs_q    <= 1'b1;
          wn_q    <= 1'b0;
          addr_q  <= A_STAT;
          state_q <= CLR;
        end
        CLR: begin
          done_q  <= irq_hit_q ? (NREQ'(1) << own_q) : '0;
          state_q <= DONE;
        end
        DONE: begin
          grant_q   <= '0;
          irq_hit_q <= 1'b0;
`ifdef TIMER_SHARE_RR_EN
          rr_q <= (int'(own_q) == NREQ - 1) ? '0 : own_q + 1'b1;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant          = grant_q;
  assign done           = done_q;
  assign busy           = (state_q != IDLE);
  assign tmr_address    = addr_q;
  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = wn_q;
  assign tmr_writedata  = wd_q;

endmodule

// File: tb/tb_timer_share_ctrl.sv
// Scoreboard bench for timer_share_ctrl: timer writes and grants queued
// on stimulus and compared as the block produces them.
module tb_timer_share_ctrl;

  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [32*NREQ-1:0] req_period = '0;
  logic              tmr_irq = 1'b0;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [2:0]        tmr_address;
  logic              tmr_chipselect;
  logic              tmr_write_n;
  logic [15:0]       tmr_writedata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_rr = 0;

  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t expq[$];
  wr_t obsq[$];
  int  obsc[$];
  logic [NREQ-1:0] gq[$];

  timer_share_ctrl #(.NREQ(NREQ), .MIN_PERIOD(1)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .req_period(req_period),
    .grant(grant),
    .done(done),
    .busy(busy),
    .tmr_address(tmr_address),
    .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n),
    .tmr_writedata(tmr_writedata),
    .tmr_irq(tmr_irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (tmr_chipselect && !tmr_write_n) begin
      obsq.push_back(wr_t'({tmr_address, tmr_writedata}));
      obsc.push_back(cyc);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] p);
    expq.push_back(wr_t'({3'd2, p[15:0]}));
    expq.push_back(wr_t'({3'd3, p[31:16]}));
    expq.push_back(wr_t'({3'd1, 16'h0005}));
  endtask

  function automatic int next_owner(input logic [NREQ-1:0] r);
`ifdef TIMER_SHARE_RR_EN
    for (int k = 0; k < NREQ; k++)
      if (r[(exp_rr + k) % NREQ]) return (exp_rr + k) % NREQ;
`else
    for (int k = 0; k < NREQ; k++)
      if (r[k]) return k;
`endif
    return 0;
  endfunction

  task automatic test_reset;
    logic [25:0] got;
    #1 reset_n = 1'b0;
    #2;
    got = {grant, done, busy, tmr_chipselect, tmr_write_n,
           tmr_address, tmr_writedata};
    tests++;
    if (got !== {2'b0, 2'b0, 1'b0, 1'b0, 1'b1, 3'b0, 16'h0}) begin
      fails++;
      $display("FAIL reset_vals: got %h, want %h", got, 26'h0080000);
    end
    cycles(2);
    reset_n = 1'b1;
    cycles(1);
  endtask

  task automatic test_contention;
    int ow;
    logic [NREQ-1:0] ex;
    wr_t e, o;
    req_period = {32'h0002_0003, 32'h0000_0010};
    req = 2'b11;
    for (int it = 0; it < 4; it++) begin
      ow = next_owner(req);
      gq.push_back(NREQ'(1) << ow);
      push_seq(req_period[32*ow +: 32]);
      expq.push_back(wr_t'({3'd0, 16'h0}));
      for (int k = 0; k < 8 && grant == '0; k++) cycles(1);
      ex = gq.pop_front();
      tests++;
      if (grant !== ex) begin
        fails++;
        $display("FAIL cont_grant it=%0d: got %b, want %b", it, grant, ex);
      end
      cycles(3);
      tmr_irq = 1'b1;
      cycles(1);
      tmr_irq = 1'b0;
      cycles(1);
      tests++;
      if (done !== ex) begin
        fails++;
        $display("FAIL cont_done it=%0d: got %b, want %b", it, done, ex);
      end
      exp_rr = (ow + 1) % NREQ;
      req[ow] = 1'b0;
      cycles(1);
      req = (it < 3) ? 2'b11 : 2'b00;
    end
    while (expq.size() > 0) begin
      e = expq.pop_front();
      tests++;
      if (obsq.size() == 0) begin
        fails++;
        $display("FAIL cont_wr: got none, want a=%0d d=%h", e.a, e.d);
      end else begin
        o = obsq.pop_front();
        void'(obsc.pop_front());
        if (o !== e) begin
          fails++;
          $display("FAIL cont_wr: got a=%0d d=%h, want a=%0d d=%h",
                   o.a, o.d, e.a, e.d);
        end
      end
    end
    tests++;
    if (obsq.size() != 0) begin
      fails++;
      $display("FAIL cont_extra: got %0d writes, want 0", obsq.size());
      obsq.delete();
      obsc.delete();
    end
  endtask

  task automatic test_single;
    int ow, t0, i;
    int c[3];
    wr_t e, o;
    req_period[31:0] = 32'h0001_86A0;
    ow = next_owner(2'b01);
    push_seq(req_period[31:0]);
    t0 = cyc;
    req = 2'b01;
    cycles(4);
    tests++;
    if (grant !== 2'b01 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_grant: got %b/%b, want 01/1", grant, busy);
    end
    i = 0;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      tests++;
      if (obsq.size() == 0) begin
        fails++;
        $display("FAIL single_wr: got none, want a=%0d d=%h", e.a, e.d);
      end else begin
        o = obsq.pop_front();
        c[i] = obsc.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL single_wr: got a=%0d d=%h, want a=%0d d=%h",
                   o.a, o.d, e.a, e.d);
        end
      end
      i++;
    end
    tests++;
    if (c[0] != t0 + 2 || c[1] != t0 + 3 || c[2] != t0 + 4) begin
      fails++;
      $display("FAIL single_timing: got %0d %0d %0d, want %0d %0d %0d",
               c[0], c[1], c[2], t0 + 2, t0 + 3, t0 + 4);
    end
    cycles(5);
    tmr_irq = 1'b1;
    expq.push_back(wr_t'({3'd0, 16'h0}));
    cycles(1);
    tmr_irq = 1'b0;
    tests++;
    if (done !== 2'b00) begin
      fails++;
      $display("FAIL single_early_done: got %b, want 00", done);
    end
    cycles(1);
    tests++;
    if (done !== 2'b01) begin
      fails++;
      $display("FAIL single_done: got %b, want 01", done);
    end
    exp_rr = (ow + 1) % NREQ;
    req = 2'b00;
    cycles(1);
    tests++;
    if ({done, grant, busy} !== 5'b0) begin
      fails++;
      $display("FAIL single_idle: got %b, want 00000", {done, grant, busy});
    end
    while (expq.size() > 0) begin
      e = expq.pop_front();
      tests++;
      if (obsq.size() == 0) begin
        fails++;
        $display("FAIL single_clr: got none, want a=%0d d=%h", e.a, e.d);
      end else begin
        o = obsq.pop_front();
        void'(obsc.pop_front());
        if (o !== e) begin
          fails++;
          $display("FAIL single_clr: got a=%0d d=%h, want a=%0d d=%h",
                   o.a, o.d, e.a, e.d);
        end
      end
    end
  endtask

  // drop-out paths: abort, irq racing a req drop, period clamps
  task automatic test_abort_and_edges;
    int ow;
    logic [NREQ-1:0] seen;
    wr_t e, o;
    for (int sc = 0; sc < 3; sc++) begin
      unique case (sc)
        0: begin req_period = {32'h0000_0020, 32'h0}; req = 2'b10; end
        1: begin req_period = {32'h0, 32'h0}; req = 2'b01; end
        default: begin req_period = {32'hFFFF_FFFF, 32'h0}; req = 2'b10; end
      endcase
      ow = next_owner(req);
      push_seq((req_period[32*ow +: 32] == 0) ? 32'h1 : req_period[32*ow +: 32]);
      for (int k = 0; k < 8 && grant == '0; k++) cycles(1);
      tests++;
      if (grant !== (NREQ'(1) << ow)) begin
        fails++;
        $display("FAIL edge_grant sc=%0d: got %b, want %b", sc, grant,
                 NREQ'(1) << ow);
      end
      cycles(3);
      if (sc == 1) begin
        tmr_irq = 1'b1;
        req = 2'b00;
        expq.push_back(wr_t'({3'd0, 16'h0}));
      end else begin
        cycles(10);
        req = 2'b00;
        expq.push_back(wr_t'({3'd1, 16'h0008}));
        expq.push_back(wr_t'({3'd0, 16'h0}));
      end
      seen = '0;
      for (int k = 0; k < 4; k++) begin
        cycles(1);
        tmr_irq = 1'b0;
        seen |= done;
      end
      tests++;
      if (seen !== ((sc == 1) ? 2'b01 : 2'b00)) begin
        fails++;
        $display("FAIL edge_done sc=%0d: got %b, want %b", sc, seen,
                 (sc == 1) ? 2'b01 : 2'b00);
      end
      tests++;
      if ({grant, busy} !== 3'b0) begin
        fails++;
        $display("FAIL edge_idle sc=%0d: got %b, want 000", sc, {grant, busy});
      end
      exp_rr = (ow + 1) % NREQ;
      while (expq.size() > 0) begin
        e = expq.pop_front();
        tests++;
        if (obsq.size() == 0) begin
          fails++;
          $display("FAIL edge_wr sc=%0d: got none, want a=%0d d=%h", sc, e.a, e.d);
        end else begin
          o = obsq.pop_front();
          void'(obsc.pop_front());
          if (o !== e) begin
            fails++;
            $display("FAIL edge_wr sc=%0d: got a=%0d d=%h, want a=%0d d=%h",
                     sc, o.a, o.d, e.a, e.d);
          end
        end
      end
      tests++;
      if (obsq.size() != 0) begin
        fails++;
        $display("FAIL edge_extra sc=%0d: got %0d writes, want 0", sc, obsq.size());
        obsq.delete();
        obsc.delete();
      end
    end
  endtask

  task automatic test_stale_irq;
    tmr_irq = 1'b1;
    cycles(3);
    tmr_irq = 1'b0;
    tests++;
    if ({grant, busy, done} !== 5'b0 || obsq.size() != 0) begin
      fails++;
      $display("FAIL stale_irq: got %b/%0d writes, want 00000/0",
               {grant, busy, done}, obsq.size());
      obsq.delete();
      obsc.delete();
    end
  endtask

  task automatic test_reset_mid;
    logic [25:0] got;
    wr_t e, o;
    req_period[31:0] = 32'h0000_0030;
    req = 2'b01;
    expq.push_back(wr_t'({3'd2, 16'h0030}));
    expq.push_back(wr_t'({3'd3, 16'h0000}));
    for (int k = 0; k < 8 && grant == '0; k++) cycles(1);
    cycles(1);
    #5;
    reset_n = 1'b0;
    #1;
    got = {grant, done, busy, tmr_chipselect, tmr_write_n,
           tmr_address, tmr_writedata};
    tests++;
    if (got !== {2'b0, 2'b0, 1'b0, 1'b0, 1'b1, 3'b0, 16'h0}) begin
      fails++;
      $display("FAIL midreset_vals: got %h, want %h", got, 26'h0080000);
    end
    #1 reset_n = 1'b1;
    exp_rr = 0;
    push_seq(32'h0000_0030);
    expq.push_back(wr_t'({3'd1, 16'h0008}));
    expq.push_back(wr_t'({3'd0, 16'h0}));
    for (int k = 0; k < 8 && grant == '0; k++) cycles(1);
    tests++;
    if (grant !== 2'b01) begin
      fails++;
      $display("FAIL midreset_regrant: got %b, want 01", grant);
    end
    cycles(3);
    req = 2'b00;
    cycles(4);
    while (expq.size() > 0) begin
      e = expq.pop_front();
      tests++;
      if (obsq.size() == 0) begin
        fails++;
        $display("FAIL midreset_wr: got none, want a=%0d d=%h", e.a, e.d);
      end else begin
        o = obsq.pop_front();
        void'(obsc.pop_front());
        if (o !== e) begin
          fails++;
          $display("FAIL midreset_wr: got a=%0d d=%h, want a=%0d d=%h",
                   o.a, o.d, e.a, e.d);
        end
      end
    end
    tests++;
    if (obsq.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_end: got %0d extra/busy %b, want 0/0",
               obsq.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_abort_and_edges();
    test_stale_irq();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
